conv_output_tracker: RTL

CONV_OUTPUT_TRACKER -- requirements
Module: conv_output_tracker

---
 rtl/conv_output_tracker.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/conv_output_tracker.sv
// Tracks the output beats of a convolution layer: checks their (y, x, ch) order against the
// stride, counts and sums them, and flags order mismatches, idle timeouts and extra beats.
module conv_output_tracker #(
  parameter int unsigned IO_DATA_WIDTH      = 16,
  parameter int unsigned FEATURE_MAP_WIDTH  = 128,
  parameter int unsigned FEATURE_MAP_HEIGHT = 128,
  parameter int unsigned OUTPUT_NB_CHANNELS = 16,
  parameter int unsigned TIMEOUT_CYCLES     = 4096
) (
  input  logic                                  clk,
  input  logic                                  arst_n_in,
  input  logic                                  start,
  input  logic                                  conv_stride_mode,
  input  logic                                  output_valid,
  input  logic [IO_DATA_WIDTH-1:0]              out,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error,
  output logic [1:0]                            err_code,
  output logic [31:0]                           out_count,
  output logic [31:0]                           checksum
);

  localparam int unsigned XW = $clog2(FEATURE_MAP_WIDTH);
  localparam int unsigned YW = $clog2(FEATURE_MAP_HEIGHT);
  localparam int unsigned CW = $clog2(OUTPUT_NB_CHANNELS);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StError} state_e;

  state_e         state_q, state_d;
  logic           stride2_q, stride2_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [CW-1:0]  ch_q, ch_d;
  logic [31:0]    count_q, count_d;
  logic [31:0]    sum_q, sum_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [1:0]     err_q, err_d;

  int unsigned    step, x_next, y_next, timer_inc;
  logic           ch_last, x_last, y_last, match;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q   <= StIdle;
      stride2_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      ch_q      <= '0;
      count_q   <= '0;
      sum_q     <= '0;
      timer_q   <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      stride2_q <= stride2_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ch_q      <= ch_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stride2_d = stride2_q;
    x_d       = x_q;
    y_d       = y_q;
    ch_d      = ch_q;
    count_d   = count_q;
    sum_d     = sum_q;
    timer_d   = timer_q;
    err_d     = err_q;

    // Wide arithmetic so x+S / y+S never wrap before being compared with the map size.
    step      = stride2_q ? 32'd2 : 32'd1;
    x_next    = 32'(x_q) + step;
    y_next    = 32'(y_q) + step;
    timer_inc = 32'(timer_q) + 32'd1;
    ch_last   = (32'(ch_q) == OUTPUT_NB_CHANNELS - 1);
    x_last    = (x_next >= FEATURE_MAP_WIDTH);
    y_last    = (y_next >= FEATURE_MAP_HEIGHT);
    match     = (output_x == x_q) && (output_y == y_q) && (output_ch == ch_q);

    if (start && (state_q != StRun)) begin
      state_d   = StRun;
      stride2_d = conv_stride_mode;
      x_d       = '0;
      y_d       = '0;
      ch_d      = '0;
      count_d   = '0;
      sum_d     = '0;
      timer_d   = '0;
      err_d     = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (output_valid) begin
            timer_d = '0;
            if (match) begin
              count_d = count_q + 32'd1;
              sum_d   = sum_q + 32'($signed(out));
              if (ch_last && x_last && y_last) begin
                state_d = StDone;
              end else if (ch_last) begin
                ch_d = '0;
                if (x_last) begin
                  x_d = '0;
                  y_d = YW'(y_next);
                end else begin
                  x_d = XW'(x_next);
                end
              end else begin
                ch_d = CW'(32'(ch_q) + 32'd1);
              end
            end else begin
              state_d = StError;
              err_d   = 2'd1;
            end
          end else begin
            timer_d = TW'(timer_inc);
            if (timer_inc >= TIMEOUT_CYCLES) begin
              state_d = StError;
              err_d   = 2'd2;
            end
          end
        end
        StDone: begin
          if (output_valid) begin
            state_d = StError;
            err_d   = 2'd3;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == StRun);
    done      = (state_q == StDone);
    error     = (state_q == StError);
    err_code  = err_q;
    out_count = count_q;
    checksum  = sum_q;
  end

endmodule
